tmr_scrub_controller: RTL and testbench

- Background scrubber for a K-modular-redundant register bank whose read path is voted by an external majority voter array.
- Periodically sweeps every word: reads all replicas, takes the voted value and mismatch flag, and writes the voted value back to all replicas when they disagree.
- Shares the bank port with user accesses; the user always has priority.
- Reports per-sweep completion, a corrected-error count and the last corrected address.

---
 rtl/tmr_scrub_controller.sv | 182 ++++++++++++++++++
 tb/tb_tmr_scrub_controller.sv | 362 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tmr_scrub_controller.sv
// Background scrubber for a voted K-modular-redundant register bank; shares the bank port with user traffic.
// Optional post-correction re-read verification is enabled by defining TMR_SCRUB_VERIFY_EN.
module tmr_scrub_controller #(
    parameter int N            = 16,
    parameter int DEPTH        = 64,
    parameter int ADDR_W       = $clog2(DEPTH),
    parameter int SCRUB_PERIOD = 1024,
    parameter int CNT_W        = 16
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              enable_i,
    input  logic              start_i,
    input  logic              user_busy_i,
    input  logic              user_wr_i,
    input  logic [ADDR_W-1:0] user_addr_i,
    output logic              rd_en_o,
    output logic [ADDR_W-1:0] rd_addr_o,
    input  logic [N-1:0]      voted_i,
    input  logic              mismatch_i,
    output logic              wr_en_o,
    output logic [ADDR_W-1:0] wr_addr_o,
    output logic [N-1:0]      wr_data_o,
    output logic              busy_o,
    output logic              sweep_done_o,
    input  logic              clr_cnt_i,
    output logic [CNT_W-1:0]  err_count_o,
    output logic [ADDR_W-1:0] last_err_addr_o
`ifdef TMR_SCRUB_VERIFY_EN
    ,
    output logic              persistent_err_o,
    output logic [ADDR_W-1:0] persistent_addr_o
`endif
);

    localparam int TMR_W = (SCRUB_PERIOD > 1) ? $clog2(SCRUB_PERIOD) : 1;
    localparam logic [TMR_W-1:0]  TMR_LAST  = TMR_W'((SCRUB_PERIOD > 0) ? SCRUB_PERIOD - 1 : 0);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    typedef enum logic [2:0] {
        IDLE,
        READ,
        CHECK,
        WRITE,
        DONE,
        VERIFY_RD,
        VERIFY_CHK
    } state_t;

    state_t            state_q;
    logic [ADDR_W-1:0] addr_q;
    logic [N-1:0]      data_q;
    logic [TMR_W-1:0]  timer_q;
    logic [CNT_W-1:0]  err_cnt_q;
    logic [ADDR_W-1:0] last_addr_q;

    logic              wb_cancel;
    logic              tmr_fire;
    state_t            adv_state;
    logic [ADDR_W-1:0] adv_addr;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    // A user write to the word under repair makes the voted copy stale.
    assign wb_cancel = user_wr_i && (user_addr_i == addr_q);
    assign tmr_fire  = (SCRUB_PERIOD != 0) && enable_i && (timer_q == TMR_LAST);
    assign adv_state = (addr_q == LAST_ADDR) ? DONE : READ;
    assign adv_addr  = (addr_q == LAST_ADDR) ? addr_q : addr_q + 1'b1;

    assign rd_en_o         = ((state_q == READ) || (state_q == VERIFY_RD)) && !user_busy_i;
    assign rd_addr_o       = addr_q;
    assign wr_en_o         = (state_q == WRITE) && !user_busy_i && !wb_cancel;
    assign wr_addr_o       = addr_q;
    assign wr_data_o       = data_q;
    assign busy_o          = (state_q != IDLE);
    assign sweep_done_o    = (state_q == DONE);
    assign err_count_o     = err_cnt_q;
    assign last_err_addr_o = last_addr_q;

`ifdef TMR_SCRUB_VERIFY_EN
    logic              pers_err_q;
    logic [ADDR_W-1:0] pers_addr_q;

    assign persistent_err_o  = pers_err_q;
    assign persistent_addr_o = pers_addr_q;
`endif

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            data_q      <= '0;
            timer_q     <= '0;
            err_cnt_q   <= '0;
            last_addr_q <= '0;
`ifdef TMR_SCRUB_VERIFY_EN
            pers_err_q  <= 1'b0;
            pers_addr_q <= '0;
`endif
        end else begin
            if (clr_cnt_i) begin
                err_cnt_q <= '0;
            end else if (wr_en_o) begin
                err_cnt_q <= sat_inc(err_cnt_q);
            end
            if (wr_en_o) begin
                last_addr_q <= addr_q;
            end

            case (state_q)
                IDLE: begin
                    if (start_i || tmr_fire) begin
                        state_q <= READ;
                        addr_q  <= '0;
                        timer_q <= '0;
                    end else if (enable_i && (SCRUB_PERIOD != 0)) begin
                        timer_q <= timer_q + 1'b1;
                    end else begin
                        timer_q <= '0;
                    end
                end
                READ: begin
                    if (!user_busy_i) begin
                        state_q <= CHECK;
                    end
                end
                CHECK: begin
                    data_q <= voted_i;
                    if (mismatch_i && !wb_cancel) begin
                        state_q <= WRITE;
                    end else begin
                        state_q <= adv_state;
                        addr_q  <= adv_addr;
                    end
                end
                WRITE: begin
                    if (wb_cancel) begin
                        state_q <= adv_state;
                        addr_q  <= adv_addr;
                    end else if (!user_busy_i) begin
`ifdef TMR_SCRUB_VERIFY_EN
                        state_q <= VERIFY_RD;
`else
                        state_q <= adv_state;
                        addr_q  <= adv_addr;
`endif
                    end
                end
`ifdef TMR_SCRUB_VERIFY_EN
                VERIFY_RD: begin
                    if (!user_busy_i) begin
                        state_q <= VERIFY_CHK;
                    end
                end
                VERIFY_CHK: begin
                    if (mismatch_i) begin
                        pers_err_q  <= 1'b1;
                        pers_addr_q <= addr_q;
                    end
                    state_q <= adv_state;
                    addr_q  <= adv_addr;
                end
`endif
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase

`ifdef TMR_SCRUB_VERIFY_EN
            if (clr_cnt_i) begin
                pers_err_q <= 1'b0;
            end
`endif
        end
    end

endmodule

// File: tb/tb_tmr_scrub_controller.sv
// Bench for tmr_scrub_controller: models a 3-replica bank with majority voter and checks each sweep
// against an operation-list timing model, using fixed sweep vectors, hand-built corner cases and random sweeps.
`timescale 1ns/1ps
module tb_tmr_scrub_controller;

    localparam int N      = 16;
    localparam int DEPTH  = 8;
    localparam int ADDR_W = 3;
    localparam int PERIOD = 16;
    localparam int CNT_W  = 2;
    localparam int SCHED  = 512;

    logic              clk = 1'b0;
    logic              rst_n_i;
    logic              enable_i;
    logic              start_i;
    logic              user_busy_i;
    logic              user_wr_i;
    logic [ADDR_W-1:0] user_addr_i;
    logic              rd_en_o;
    logic [ADDR_W-1:0] rd_addr_o;
    logic [N-1:0]      voted_i;
    logic              mismatch_i;
    logic              wr_en_o;
    logic [ADDR_W-1:0] wr_addr_o;
    logic [N-1:0]      wr_data_o;
    logic              busy_o;
    logic              sweep_done_o;
    logic              clr_cnt_i;
    logic [CNT_W-1:0]  err_count_o;
    logic [ADDR_W-1:0] last_err_addr_o;

    always #5 clk = ~clk;

    tmr_scrub_controller #(
        .N(N), .DEPTH(DEPTH), .SCRUB_PERIOD(PERIOD), .CNT_W(CNT_W)
    ) dut (
        .clk_i(clk), .rst_n_i(rst_n_i), .enable_i(enable_i), .start_i(start_i),
        .user_busy_i(user_busy_i), .user_wr_i(user_wr_i), .user_addr_i(user_addr_i),
        .rd_en_o(rd_en_o), .rd_addr_o(rd_addr_o), .voted_i(voted_i), .mismatch_i(mismatch_i),
        .wr_en_o(wr_en_o), .wr_addr_o(wr_addr_o), .wr_data_o(wr_data_o),
        .busy_o(busy_o), .sweep_done_o(sweep_done_o), .clr_cnt_i(clr_cnt_i),
        .err_count_o(err_count_o), .last_err_addr_o(last_err_addr_o)
    );

    logic [N-1:0] rep  [3][DEPTH];
    logic [N-1:0] base [DEPTH];
    int           rd_a_q[$], rd_c_q[$], wr_a_q[$], wr_c_q[$];
    logic [N-1:0] wr_d_q[$];
    bit           busy_sched [SCHED];
    bit           uwr_sched  [SCHED];
    bit           clr_sched  [SCHED];
    logic [N-1:0] user_data;
    int           cyc = 0;
    int           done_cyc = -1;
    int           vectors = 0;
    int           miscompares = 0;
    int           exp_last = 0;

    typedef struct {
        logic [DEPTH-1:0] mask;
        int               busy_lo;
        int               busy_hi;
        int               exp_done;
        int               exp_cnt;
        int               exp_last;
    } vec_t;

    task automatic chk(input string nm, input longint act, input longint exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    function automatic logic [N-1:0] vote(input int a);
        if (rep[0][a] == rep[1][a] || rep[0][a] == rep[2][a]) return rep[0][a];
        return rep[1][a];
    endfunction

    function automatic bit disagree(input int a);
        return !(rep[0][a] == rep[1][a] && rep[1][a] == rep[2][a]);
    endfunction

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Bank, voter and port monitor: one pass per cycle, sampled mid-cycle.
    initial begin
        bit          p_rd;
        int          p_addr;
        voted_i    = '0;
        mismatch_i = 1'b0;
        forever begin
            @(negedge clk);
            p_rd   = rd_en_o;
            p_addr = int'(rd_addr_o);
            if (rd_en_o) begin
                rd_a_q.push_back(int'(rd_addr_o));
                rd_c_q.push_back(cyc);
            end
            if (wr_en_o) begin
                wr_a_q.push_back(int'(wr_addr_o));
                wr_c_q.push_back(cyc);
                wr_d_q.push_back(wr_data_o);
                for (int r = 0; r < 3; r++) rep[r][wr_addr_o] = wr_data_o;
            end
            if (user_wr_i) begin
                base[user_addr_i] = user_data;
                for (int r = 0; r < 3; r++) rep[r][user_addr_i] = user_data;
            end
            if (user_busy_i) chk("port idle while user busy", longint'(rd_en_o | wr_en_o), 0);
            if (sweep_done_o && done_cyc < 0) done_cyc = cyc;
            @(posedge clk);
            #1;
            if (p_rd) begin
                voted_i    = vote(p_addr);
                mismatch_i = disagree(p_addr);
            end else begin
                voted_i    = N'($urandom);
                mismatch_i = 1'($urandom_range(0, 1));
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic set_word(input int a, input logic [N-1:0] v, input bit bad);
        base[a] = v;
        for (int r = 0; r < 3; r++) rep[r][a] = v;
        if (bad) rep[$urandom_range(0, 2)][a] = v ^ N'($urandom_range(1, 65535));
    endtask

    task automatic setup_bank(input logic [DEPTH-1:0] mask);
        for (int a = 0; a < DEPTH; a++) set_word(a, N'($urandom), mask[a]);
    endtask

    task automatic clear_sched();
        for (int k = 0; k < SCHED; k++) begin
            busy_sched[k] = 1'b0;
            uwr_sched[k]  = 1'b0;
            clr_sched[k]  = 1'b0;
        end
    endtask

    task automatic clear_events();
        rd_a_q.delete(); rd_c_q.delete();
        wr_a_q.delete(); wr_c_q.delete(); wr_d_q.delete();
        done_cyc = -1;
    endtask

    task automatic clr_count();
        @(posedge clk); #1; clr_cnt_i = 1'b1;
        @(posedge clk); #1; clr_cnt_i = 1'b0;
        chk("counter cleared", longint'(err_count_o), 0);
    endtask

    task automatic bank_check(input string nm);
        int bad = 0;
        for (int a = 0; a < DEPTH; a++) if (disagree(a)) bad++;
        chk({nm, " replicas agree"}, bad, 0);
    endtask

    task automatic check_zero(input string nm);
        chk(nm, longint'({rd_en_o, rd_addr_o, wr_en_o, wr_addr_o, wr_data_o, busy_o,
                          sweep_done_o, err_count_o, last_err_addr_o}), 0);
    endtask

    task automatic run_sweep(output int st);
        clear_events();
        @(posedge clk); #1;
        start_i = 1'b1;
        st = cyc;
        user_busy_i = busy_sched[0]; user_wr_i = uwr_sched[0]; clr_cnt_i = clr_sched[0];
        for (int k = 1; k < 400; k++) begin
            @(posedge clk); #1;
            start_i = 1'b0;
            if (done_cyc >= 0) break;
            user_busy_i = (k < SCHED) ? busy_sched[k] : 1'b0;
            user_wr_i   = (k < SCHED) ? uwr_sched[k]  : 1'b0;
            clr_cnt_i   = (k < SCHED) ? clr_sched[k]  : 1'b0;
        end
        user_busy_i = 1'b0; user_wr_i = 1'b0; clr_cnt_i = 1'b0;
        if (done_cyc < 0) chk("sweep completes within bound", 0, 1);
    endtask

    task automatic wait_done(input bit drop_en);
        for (int k = 0; k < 400; k++) begin
            @(posedge clk); #1;
            if (drop_en && rd_a_q.size() > 0) enable_i = 1'b0;
            if (done_cyc >= 0) break;
        end
        if (done_cyc < 0) chk("auto sweep completes within bound", 0, 1);
    endtask

    // Reference: each word is a port read, one voter cycle, and a port write if corrupted;
    // port operations slide past cycles the user holds the port.
    task automatic check_sweep(input string nm, input int st, input logic [DEPTH-1:0] mask,
                               input int exp_cnt, input int exp_la);
        int           t;
        int           er_a[$], er_c[$], ew_a[$], ew_c[$];
        logic [N-1:0] ew_d[$];
        t = st + 1;
        for (int a = 0; a < DEPTH; a++) begin
            while (t - st < SCHED && busy_sched[t - st]) t++;
            er_a.push_back(a); er_c.push_back(t);
            t += 2;
            if (mask[a]) begin
                while (t - st < SCHED && busy_sched[t - st]) t++;
                ew_a.push_back(a); ew_c.push_back(t); ew_d.push_back(base[a]);
                t++;
            end
        end
        chk({nm, " read count"}, rd_a_q.size(), er_a.size());
        for (int i = 0; i < er_a.size() && i < rd_a_q.size(); i++) begin
            chk({nm, " read addr"}, rd_a_q[i], er_a[i]);
            chk({nm, " read cycle"}, rd_c_q[i] - st, er_c[i] - st);
        end
        chk({nm, " write count"}, wr_a_q.size(), ew_a.size());
        for (int i = 0; i < ew_a.size() && i < wr_a_q.size(); i++) begin
            chk({nm, " write addr"}, wr_a_q[i], ew_a[i]);
            chk({nm, " write cycle"}, wr_c_q[i] - st, ew_c[i] - st);
            chk({nm, " write data"}, longint'(wr_d_q[i]), longint'(ew_d[i]));
        end
        chk({nm, " done cycle"}, done_cyc - st, t - st);
        chk({nm, " err count"}, longint'(err_count_o), exp_cnt);
        chk({nm, " last err addr"}, longint'(last_err_addr_o), exp_la);
        bank_check(nm);
    endtask

    initial begin
        vec_t tv[8];
        int   st, e, d, pop;

        tv[0] = '{8'h00, 1, 0, 17, 0, 0};
        tv[1] = '{8'h08, 1, 0, 18, 1, 3};
        tv[2] = '{8'h00, 3, 6, 21, 0, 3};
        tv[3] = '{8'h42, 1, 0, 19, 2, 6};
        tv[4] = '{8'h01, 2, 3, 19, 1, 0};
        tv[5] = '{8'hFF, 1, 0, 25, 3, 7};
        tv[6] = '{8'h80, 0, 0, 18, 1, 7};
        tv[7] = '{8'h00, 1, 1, 18, 0, 7};

        rst_n_i = 1'b0; enable_i = 1'b0; start_i = 1'b0; user_busy_i = 1'b0;
        user_wr_i = 1'b0; user_addr_i = '0; clr_cnt_i = 1'b0; user_data = '0;
        clear_sched();
        setup_bank('0);
        repeat (3) @(posedge clk);
        #1;
        check_zero("reset outputs");
        rst_n_i = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_zero("idle after reset");

        for (int i = 0; i < 8; i++) begin
            clear_sched();
            clr_count();
            setup_bank(tv[i].mask);
            if (tv[i].mask == 8'h08) set_word(3, 16'h00A5, 1'b1);
            for (int k = tv[i].busy_lo; k <= tv[i].busy_hi; k++) busy_sched[k] = 1'b1;
            run_sweep(st);
            chk($sformatf("vector %0d done offset", i), done_cyc - st, tv[i].exp_done);
            check_sweep($sformatf("vector %0d", i), st, tv[i].mask, tv[i].exp_cnt, tv[i].exp_last);
            exp_last = tv[i].exp_last;
        end

        // User write to the word in CHECK cancels the write-back.
        clear_sched(); clr_count(); setup_bank(8'h20);
        user_addr_i = 3'd5; user_data = 16'h5A5A;
        uwr_sched[12] = 1'b1; busy_sched[12] = 1'b1;
        run_sweep(st);
        chk("cancel in CHECK done offset", done_cyc - st, 17);
        chk("cancel in CHECK writes", wr_a_q.size(), 0);
        chk("cancel in CHECK count", longint'(err_count_o), 0);
        chk("cancel in CHECK user data kept", longint'(rep[0][5]), 16'h5A5A);
        chk("cancel in CHECK last err addr", longint'(last_err_addr_o), exp_last);
        bank_check("cancel in CHECK");

        // User write to the word while the write-back is stalled in WRITE.
        clear_sched(); setup_bank(8'h04);
        user_addr_i = 3'd2; user_data = 16'hC3C3;
        uwr_sched[7] = 1'b1; busy_sched[7] = 1'b1;
        run_sweep(st);
        chk("cancel in WRITE done offset", done_cyc - st, 18);
        chk("cancel in WRITE writes", wr_a_q.size(), 0);
        chk("cancel in WRITE count", longint'(err_count_o), 0);
        chk("cancel in WRITE user data kept", longint'(rep[1][2]), 16'hC3C3);
        bank_check("cancel in WRITE");

        // Timer-driven sweeps, counter saturation, and enable dropped mid-sweep.
        clear_sched(); clr_count(); setup_bank(8'h52); clear_events();
        @(posedge clk); #1;
        enable_i = 1'b1;
        e = cyc;
        wait_done(1'b0);
        check_sweep("auto sweep 1", e + 15, 8'h52, 3, 6);
        d = done_cyc;
        setup_bank(8'h21);
        clear_events();
        wait_done(1'b1);
        check_sweep("auto sweep 2", d + 16, 8'h21, 3, 5);
        exp_last = 5;
        clear_events();
        repeat (40) @(posedge clk);
        #1;
        chk("no timer sweep while disabled", rd_a_q.size(), 0);

        // Clear coinciding with an increment leaves zero.
        clear_sched(); setup_bank(8'h04);
        clr_sched[7] = 1'b1;
        run_sweep(st);
        check_sweep("clear beats increment", st, 8'h04, 0, 2);
        exp_last = 2;

        // Reset in WRITE drops the pending write at once.
        clear_sched(); setup_bank(8'h08); clear_events();
        @(posedge clk); #1;
        start_i = 1'b1;
        st = cyc;
        repeat (9) begin
            @(posedge clk); #1;
            start_i = 1'b0;
        end
        #1;
        chk("write pending before reset", longint'(wr_en_o), 1);
        rst_n_i = 1'b0;
        #1;
        check_zero("outputs during mid-sweep reset");
        @(posedge clk); #3;
        rst_n_i = 1'b1;
        chk("no write reached bank during reset", wr_a_q.size(), 0);
        exp_last = 0;
        run_sweep(st);
        check_sweep("sweep after reset", st, 8'h08, 1, 3);
        exp_last = 3;

        for (int it = 0; it < 12; it++) begin
            logic [DEPTH-1:0] m;
            clear_sched();
            m = DEPTH'($urandom);
            for (int k = 0; k < 120; k++) busy_sched[k] = ($urandom_range(0, 3) == 0);
            clr_count();
            setup_bank(m);
            run_sweep(st);
            pop = $countones(m);
            for (int a = 0; a < DEPTH; a++) if (m[a]) exp_last = a;
            check_sweep($sformatf("random %0d", it), st, m, (pop > 3) ? 3 : pop, exp_last);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
